// File: rtl/clz_iter_unit_pkg.sv
// Shared types and constants for the iterative leading-zero/one counter.
package clz_iter_pkg;

  localparam int CLZ_W = 32;
  localparam int CNT_W = 6;

  // Bit n set means STEP_BITS = n is a legal slice width.
  localparam int LEGAL_STEP_MASK = 32'h0000_0116;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  function automatic bit step_bits_legal(input int step);
    return (step > 0) && (step < 32) && LEGAL_STEP_MASK[step];
  endfunction

endpackage

// File: rtl/clz_iter_unit_if.sv
// Start/busy/done handshake bundle between the execute stage and the CLZ/CLO unit.
interface clz_iter_unit_if;
  import clz_iter_pkg::*;

  logic             start;
  logic             op_clo;
  logic [CLZ_W-1:0] operand;
  logic             flush;
  logic             busy;
  logic             done;
  logic [CLZ_W-1:0] result;

  modport master (
    output start, op_clo, operand, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op_clo, operand, flush,
    output busy, done, result
  );

endinterface

// File: rtl/clz_iter_unit_slice_lzc.sv
// Combinational leading-zero count of one STEP_BITS-wide slice (W when all zero).
module slice_lzc #(
  parameter int W = 4
) (
  input  logic [W-1:0]          slice,
  output logic [$clog2(W):0]    count
);

  localparam int LZ_W = $clog2(W) + 1;

  // Scanning upward, the last set bit seen is the most significant one.
  always_comb begin
    count = LZ_W'(W);
    for (int i = 0; i < W; i++) begin
      if (slice[i]) count = LZ_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/clz_iter_unit.sv
// Multi-cycle CLZ/CLO unit: scans STEP_BITS bits per cycle from the MSB down.
module clz_iter_unit
  import clz_iter_pkg::*;
#(
  parameter int STEP_BITS = 4
) (
  input logic           clk,
  input logic           rst_n,
  clz_iter_unit_if.slave bus
);

  localparam int LZ_W = $clog2(STEP_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLZ_W - STEP_BITS);

  generate
    if (!step_bits_legal(STEP_BITS)) begin : gen_bad_step
      $error("clz_iter_unit: STEP_BITS must be 1, 2, 4 or 8");
    end
  endgenerate

  state_t             state;
  logic [CLZ_W-1:0]   shreg;
  logic [CLZ_W-1:0]   result_q;
  logic [CNT_W-1:0]   cnt;
  logic [STEP_BITS-1:0] slice;
  logic [LZ_W-1:0]    slice_cnt;

  assign slice = shreg[CLZ_W-1 -: STEP_BITS];

  slice_lzc #(
    .W(STEP_BITS)
  ) u_slice_lzc (
    .slice(slice),
    .count(slice_cnt)
  );

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

  // CLO reuses the zero scan by inverting the operand on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            shreg <= bus.op_clo ? ~bus.operand : bus.operand;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (|slice) begin
            result_q <= CLZ_W'(cnt) + CLZ_W'(slice_cnt);
            state    <= DONE;
          end else if (cnt == LAST_CNT) begin
            result_q <= CLZ_W'(CLZ_W);
            state    <= DONE;
          end else begin
            cnt   <= cnt + CNT_W'(STEP_BITS);
            shreg <= shreg << STEP_BITS;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clz_iter_unit.sv
// Drives four clz_iter_unit instances (STEP_BITS 1, 2, 4, 8) in lockstep against a bit-loop model.
module tb_clz_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_clo = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] operand = '0;

  logic        busy_v   [4];
  logic        done_v   [4];
  logic [31:0] result_v [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : gen_dut
      clz_iter_unit_if bus ();
      assign bus.start   = start;
      assign bus.op_clo  = op_clo;
      assign bus.operand = operand;
      assign bus.flush   = flush;
      assign busy_v[g]   = bus.busy;
      assign done_v[g]   = bus.done;
      assign result_v[g] = bus.result;

      clz_iter_unit #(
        .STEP_BITS(1 << g)
      ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_clz(input logic [31:0] v);
    for (int b = 31; b >= 0; b--) begin
      if (v[b]) return 31 - b;
    end
    return 32;
  endfunction

  // Cycle (counting the start cycle as 0) in which done is expected.
  function automatic int model_lat(input int clz, input int step);
    if (clz == 32) return 32 / step + 1;
    return clz / step + 2;
  endfunction

  task automatic check_all_idle(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s busy s%0d", tag, 1 << i), busy_v[i], 1'b0);
      check($sformatf("%s done s%0d", tag, 1 << i), done_v[i], 1'b0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 60) begin
      idle = !(busy_v[0] || busy_v[1] || busy_v[2] || busy_v[3]);
      if (!idle) begin
        tick();
        n++;
      end
    end
    check({tag, " idle"}, idle, 1'b1);
  endtask

  task automatic run_op(input logic [31:0] v, input logic clo, input string tag);
    int seen [4];
    int exp_clz;
    logic all_seen;
    exp_clz = model_clz(clo ? ~v : v);
    for (int i = 0; i < 4; i++) seen[i] = -1;
    operand = v;
    op_clo  = clo;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) begin
        for (int i = 0; i < 4; i++)
          check($sformatf("%s busy1 s%0d", tag, 1 << i), busy_v[i], 1'b1);
      end
      all_seen = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (seen[i] < 0 && done_v[i] === 1'b1) begin
          seen[i] = cyc;
          check($sformatf("%s result s%0d", tag, 1 << i), result_v[i], 32'(exp_clz));
        end
        if (seen[i] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      tick();
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("%s latency s%0d", tag, 1 << i), 32'(seen[i]), 32'(model_lat(exp_clz, 1 << i)));
    tick();
    check_all_idle({tag, " after"});
  endtask

  initial begin
    logic [31:0] rv;
    int          dones;

    // Reset state
    tick();
    tick();
    check_all_idle("reset");
    for (int i = 0; i < 4; i++)
      check($sformatf("reset result s%0d", 1 << i), result_v[i], 32'd0);
    rst_n = 1'b1;
    tick();

    // Boundary operands
    run_op(32'h8000_0000, 1'b0, "clz_msb");
    run_op(32'h7FFF_FFFF, 1'b1, "clo_zero");
    run_op(32'h0000_0001, 1'b0, "clz_lsb");
    run_op(32'h0000_0000, 1'b0, "clz_all0");
    run_op(32'hFFFF_FFFF, 1'b1, "clo_all1");

    // Starts during SCAN/DONE must be ignored (checked on STEP_BITS=4 instance)
    operand = 32'h0010_0000;
    op_clo  = 1'b0;
    start   = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 4; cyc++) begin
      operand = 32'hF000_0000 ^ (32'(cyc) * 32'h1111);
      op_clo  = cyc[0];
      start   = 1'b1;
      if (cyc < 4) begin
        check($sformatf("ign busy c%0d", cyc), busy_v[2], 1'b1);
        check($sformatf("ign done c%0d", cyc), done_v[2], 1'b0);
        check($sformatf("ign result c%0d", cyc), result_v[2], 32'd32);
      end else begin
        check("ign done c4", done_v[2], 1'b1);
        check("ign result c4", result_v[2], 32'd11);
      end
      tick();
    end
    start = 1'b0;
    check("ign busy c5", busy_v[2], 1'b0);
    wait_idle("ign");

    // Flush in cycle 3 of a long scan
    operand = 32'h0000_0001;
    op_clo  = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_all_idle("flush c4");
    check("flush result", result_v[2], 32'd11);
    dones = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (done_v[2]) dones++;
      tick();
    end
    check("flush no done", 32'(dones), 32'd0);

    // Simultaneous start and flush in IDLE
    operand = 32'h0000_00FF;
    start   = 1'b1;
    flush   = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check_all_idle("start_flush");

    // Asynchronous reset mid-SCAN
    operand = 32'h0000_0001;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_all_idle("async_rst");
    for (int i = 0; i < 4; i++)
      check($sformatf("async_rst result s%0d", 1 << i), result_v[i], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(32'hF000_0000, 1'b1, "clo_after_rst");

    // Randomized operands with varying leading-zero depth
    for (int n = 0; n < 40; n++) begin
      rv = $urandom >> $urandom_range(0, 32);
      if ($urandom_range(0, 1) == 1) rv = ~rv;
      run_op(rv, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
